// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy encoding,
// reset PC and the payload field layout the stages pack into in_data.
package pipe_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = OCC_EMPTY,
      ST_ONE   = OCC_ONE,
      ST_FULL  = OCC_FULL
   } state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // Default 96-bit payload: instruction, ALU result, destination register, control.
   localparam int PL_INSTR_LSB  = 0;
   localparam int PL_INSTR_W    = 32;
   localparam int PL_RESULT_LSB = 32;
   localparam int PL_RESULT_W   = 32;
   localparam int PL_DST_LSB    = 64;
   localparam int PL_DST_W      = 5;
   localparam int PL_CTRL_LSB   = 69;
   localparam int PL_CTRL_W     = 27;
   localparam int PL_TOTAL_W    = PL_CTRL_LSB + PL_CTRL_W;

endpackage

// File: rtl/pipe_entry.sv
// One stage-register slot: valid flag, PC and payload with load and clear.
// A clear drops valid and payload but keeps the PC unless pc_load is also set.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              pc_load,
   input  logic [31:0]       pc_val,
   input  logic [31:0]       d_pc,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [31:0]       pc,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         pc    <= RESET_PC;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         data  <= '0;
         if (pc_load) begin
            pc <= pc_val;
         end
      end else if (load) begin
         valid <= 1'b1;
         pc    <= d_pc;
         data  <= d_data;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a two-entry skid buffer, exception and bubble
// flushes, optional PC preservation across bubbles and a saturating drop counter.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 96,
   parameter int KEEP_PC = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Req,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_cnt
);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W+1:0] sum;
      sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
      if (sum > {2'b00, {CNT_W{1'b1}}}) begin
         return {CNT_W{1'b1}};
      end
      return sum[CNT_W-1:0];
   endfunction

   state_t state, state_nxt;

   logic              main_valid, skid_valid;
   logic [31:0]       main_pc, skid_pc;
   logic [DATA_W-1:0] main_data, skid_data;

   logic              main_load, main_from_skid, main_clr, main_pc_load;
   logic [31:0]       main_pc_val;
   logic              skid_load, skid_clr, drop_ev;
   logic [31:0]       main_d_pc;
   logic [DATA_W-1:0] main_d_data;
   logic              acc, dep;

   assign in_ready = ~skid_valid;
   assign acc      = in_valid & in_ready;
   assign dep      = main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Flushes override the handshake: nothing transfers in a flush cycle.
   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clr       = 1'b0;
      main_pc_load   = 1'b0;
      main_pc_val    = RESET_PC;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      drop_ev        = 1'b0;
      if (Req) begin
         state_nxt    = ST_EMPTY;
         main_clr     = 1'b1;
         main_pc_load = 1'b1;
         skid_clr     = 1'b1;
         drop_ev      = 1'b1;
      end else if (flush) begin
         state_nxt = ST_EMPTY;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
         drop_ev   = 1'b1;
         if (KEEP_PC == 0) begin
            main_pc_load = 1'b1;
         end else if (!main_valid && in_valid) begin
            main_pc_load = 1'b1;
            main_pc_val  = in_pc;
         end
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  main_load = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && !dep) begin
                  skid_load = 1'b1;
                  state_nxt = ST_FULL;
               end else if (acc && dep) begin
                  main_load = 1'b1;
               end else if (dep) begin
                  main_clr  = 1'b1;
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (dep) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
   assign main_d_data = main_from_skid ? skid_data : in_data;

   pipe_entry #(.DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load    (main_load),
      .clear   (main_clr),
      .pc_load (main_pc_load),
      .pc_val  (main_pc_val),
      .d_pc    (main_d_pc),
      .d_data  (main_d_data),
      .valid   (main_valid),
      .pc      (main_pc),
      .data    (main_data)
   );

   pipe_entry #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clr),
      .pc_load (skid_clr),
      .pc_val  (RESET_PC),
      .d_pc    (in_pc),
      .d_data  (in_data),
      .valid   (skid_valid),
      .pc      (skid_pc),
      .data    (skid_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (drop_ev) begin
         drop_cnt <= sat_add(drop_cnt, occupancy);
      end
   end

   assign occupancy = state;
   assign out_valid = main_valid;
   assign out_data  = main_valid ? main_data : '0;
   assign out_pc    = ((KEEP_PC != 0) || main_valid) ? main_pc : RESET_PC;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a default instance (KEEP_PC=1, 8-bit count)
// and a KEEP_PC=0, 2-bit-count instance driven by the same stimulus.
module tb_pipe_skid_stage;

   localparam int DW = 96;

   logic          clk = 1'b0;
   logic          reset, Req, flush, in_valid, out_ready;
   logic [31:0]   in_pc;
   logic [DW-1:0] in_data;

   logic          a_in_ready, a_out_valid;
   logic [31:0]   a_out_pc;
   logic [DW-1:0] a_out_data;
   logic [1:0]    a_occ;
   logic [7:0]    a_drop;

   logic          b_in_ready, b_out_valid;
   logic [31:0]   b_out_pc;
   logic [DW-1:0] b_out_data;
   logic [1:0]    b_occ;
   logic [1:0]    b_drop;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DW), .KEEP_PC(1), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .Req(Req), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
      .out_data(a_out_data), .occupancy(a_occ), .drop_cnt(a_drop)
   );

   pipe_skid_stage #(.DATA_W(DW), .KEEP_PC(0), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .Req(Req), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
      .out_data(b_out_data), .occupancy(b_occ), .drop_cnt(b_drop)
   );

   function automatic logic [DW-1:0] mk(input logic [31:0] pc);
      return {pc ^ 32'hFFFF_0000, 32'h1234_5678, pc};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_data  = mk(pc);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                          input logic [1:0] occ, input logic rdy);
      check({tag, "_valid"}, a_out_valid, v);
      check({tag, "_pc"}, a_out_pc, pc);
      check({tag, "_data"}, a_out_data, v ? mk(pc) : '0);
      check({tag, "_occ"}, a_occ, occ);
      check({tag, "_rdy"}, a_in_ready, rdy);
   endtask

   initial begin
      reset = 1'b1; Req = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk_out("rst", 1'b0, 32'h0, 2'd0, 1'b1);
      check("rst_drop", a_drop, 8'd0);

      // streaming at one beat per cycle
      out_ready = 1'b1;
      drive(1'b1, 32'h3000); tick(); chk_out("st0", 1'b1, 32'h3000, 2'd1, 1'b1);
      drive(1'b1, 32'h3004); tick(); chk_out("st1", 1'b1, 32'h3004, 2'd1, 1'b1);
      drive(1'b1, 32'h3008); tick(); chk_out("st2", 1'b1, 32'h3008, 2'd1, 1'b1);
      drive(1'b0, 32'h0);    tick(); chk_out("st_empty", 1'b0, 32'h3008, 2'd0, 1'b1);
      check("st_empty_pc_nokeep", b_out_pc, 32'h0);

      // backpressure fills the skid entry and holds the third beat upstream
      out_ready = 1'b0;
      drive(1'b1, 32'h3000); tick(); chk_out("bp0", 1'b1, 32'h3000, 2'd1, 1'b1);
      drive(1'b1, 32'h3004); tick(); chk_out("bp1", 1'b1, 32'h3000, 2'd2, 1'b0);
      drive(1'b1, 32'h3008); tick(); chk_out("bp2", 1'b1, 32'h3000, 2'd2, 1'b0);
      out_ready = 1'b1;
      tick(); chk_out("dr0", 1'b1, 32'h3004, 2'd1, 1'b1);
      tick(); chk_out("dr1", 1'b1, 32'h3008, 2'd1, 1'b1);
      drive(1'b0, 32'h0);
      tick(); chk_out("dr_empty", 1'b0, 32'h3008, 2'd0, 1'b1);

      // bubble flush from FULL keeps the oldest PC
      out_ready = 1'b0;
      drive(1'b1, 32'h3010); tick();
      drive(1'b1, 32'h3014); tick(); chk_out("fl_full", 1'b1, 32'h3010, 2'd2, 1'b0);
      drive(1'b0, 32'h0); flush = 1'b1; tick(); flush = 1'b0;
      chk_out("fl", 1'b0, 32'h3010, 2'd0, 1'b1);
      check("fl_drop", a_drop, 8'd2);
      check("fl_pc_nokeep", b_out_pc, 32'h0);
      check("fl_drop_sat", b_drop, 2'd2);

      // Req together with flush wins and counts once
      drive(1'b1, 32'h4180); tick(); chk_out("rq_one", 1'b1, 32'h4180, 2'd1, 1'b1);
      drive(1'b0, 32'h0); Req = 1'b1; flush = 1'b1; tick(); Req = 1'b0; flush = 1'b0;
      chk_out("rq", 1'b0, 32'h0, 2'd0, 1'b1);
      check("rq_drop", a_drop, 8'd3);
      check("rq_drop_sat", b_drop, 2'd3);

      // flush while empty takes the offered PC and drops nothing
      drive(1'b1, 32'h5000); flush = 1'b1; tick(); flush = 1'b0;
      chk_out("fe", 1'b0, 32'h5000, 2'd0, 1'b1);
      check("fe_drop", a_drop, 8'd3);

      // another full flush: wide counter advances, 2-bit counter stays saturated
      drive(1'b1, 32'h3020); tick();
      drive(1'b1, 32'h3024); tick();
      drive(1'b0, 32'h0); flush = 1'b1; tick(); flush = 1'b0;
      check("sat_drop", a_drop, 8'd5);
      check("sat_drop_sat", b_drop, 2'd3);
      check("sat_pc", a_out_pc, 32'h3020);

      // reset while FULL and draining
      drive(1'b1, 32'h3030); tick();
      drive(1'b1, 32'h3034); tick(); chk_out("rm_full", 1'b1, 32'h3030, 2'd2, 1'b0);
      drive(1'b0, 32'h0); out_ready = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
      chk_out("rm", 1'b0, 32'h0, 2'd0, 1'b1);
      check("rm_drop", a_drop, 8'd0);
      check("rm_drop_sat", b_drop, 2'd0);
      check("rm_valid_b", b_out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-field clear-on-`Req` stage registers between MIPS pipeline stages (F/D, D/E, E/M, M/W). It adds the following on top of those registers:
- per-stage backpressure;
- separate exception flush (`Req`) and bubble flush (`flush`);
- optional preservation of the macro-instruction PC across bubbles, which CP0 needs for EPC/BD;
- a saturating count of discarded entries.

## Interface
Parameters:
- `DATA_W`, default 96: width of the opaque payload (control bits, ALU result, Dst, instruction…), excluding PC.
- `KEEP_PC`, default 1: if 1, a `flush` bubble carries the PC of the oldest dropped or held instruction. If 0, a bubble carries PC 0.
- `CNT_W`, default 8: width of `drop_cnt`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high; highest priority.
- `Req` in 1: CP0 exception/interrupt flush; clears everything including PC.
- `flush` in 1: local bubble flush (branch/stall kill); clears valid entries and payload; PC per `KEEP_PC`.
- `in_valid` in 1: upstream holds a valid instruction.
- `in_ready` out 1: stage can accept; depends only on registered state.
- `in_pc` in 32: upstream PC.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: downstream accepts this cycle.
- `out_pc` out 32: output PC.
- `out_data` out DATA_W: output payload; 0 whenever `out_valid`=0.
- `occupancy` out 2: number of held entries (0, 1, 2).
- `drop_cnt` out CNT_W: saturating count of valid entries discarded by `flush` or `Req`.

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds valid, PC and data.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid). Never skid-valid with main-invalid.
- `in_ready` = !skid_valid. `acc` = in_valid & in_ready. `dep` = out_valid & out_ready.
- EMPTY: acc → ONE, main ← in.
- ONE:
  - acc & !dep → FULL, skid ← in.
  - acc & dep → ONE, main ← in.
  - !acc & dep → EMPTY.
  - Otherwise hold.
- FULL:
  - dep → ONE, main ← skid, skid cleared.
  - !dep → hold. acc is impossible.
- Ordering: outputs are strictly FIFO. A payload is never duplicated or dropped except by flush.
- Priority per cycle: `reset` > `Req` > `flush` > handshake. A flush cycle ignores acc and dep; no transfer occurs that cycle.
- `Req`: next state EMPTY; out_pc ← 0; out_data ← 0; drop_cnt += occupancy.
- `flush`: next state EMPTY; out_data ← 0; drop_cnt += occupancy.
  - With `KEEP_PC`=1, out_pc ← main PC if main valid, else in_pc if in_valid, else hold.
  - With `KEEP_PC`=0, out_pc ← 0.
- Offered-but-unaccepted upstream data is not counted as dropped.
- drop_cnt saturates at all-ones. Only `reset` clears it.
- When EMPTY without flush, out_pc holds its last value (`KEEP_PC`=1) or is 0 (`KEEP_PC`=0).

## Timing
- Reset values: out_valid 0, out_pc 0, out_data 0, occupancy 0, drop_cnt 0, in_ready 1 (from the cycle after reset).
- Latency: 1 cycle from acc (when EMPTY) to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- `in_ready` falls the cycle after the skid entry fills, so one extra upstream beat is absorbed without combinational ready paths.
- Reset, `Req` or `flush` in any state, including FULL mid-drain, take effect at the next edge. The stage is EMPTY and in_ready=1 the following cycle.
- `Req` and `flush` together: `Req` wins (PC 0). drop_cnt is counted once.

## Structure
- Shared package `pipe_pkg`:
  - state encoding localparams (EMPTY=0, ONE=1, FULL=2);
  - the default reset PC 0;
  - the payload field offsets the stages use to pack and unpack `in_data`.
- Natural sub-module: `pipe_entry`, one valid+PC+data register with load/clear, instantiated twice.
- Only the FSM and drop counter live in the top.

## Test plan
- Streaming: in_valid=1 and out_ready=1 every cycle, PCs 0x3000, 0x3004, 0x3008 → out_pc identical sequence one cycle later; occupancy 1 throughout; in_ready always 1.
- Backpressure: out_ready=0, push 0x3000 then 0x3004 → occupancy 2, in_ready 0; 0x3008 held upstream. Then out_ready=1 → out 0x3000, 0x3004, 0x3008 in order with no loss.
- Flush, `KEEP_PC`=1: FULL with 0x3010/0x3014 and flush=1 → next cycle out_valid 0, out_data 0, out_pc 0x3010, drop_cnt 2, in_ready 1.
- `Req` with flush in the same cycle, main 0x4180 → out_pc 0, out_valid 0, drop_cnt +1 only.
- Saturation: `CNT_W`=2, repeated full flushes → drop_cnt stops at 3.
- Reset mid-drain from FULL → next cycle all outputs at reset values; drop_cnt 0.
